// File: rtl/nios_gpu_pkg.sv
// Register map, status/control bit positions and status packing shared by the
// Nios GPU instruction FIFO and its bench-facing software view.
package nios_gpu_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_IRQ_EN = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_COUNT_LSB = 16;
    localparam int ST_COUNT_W   = 8;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

    localparam int IRQ_LOW_WATER = 0;
    localparam int IRQ_OVERFLOW  = 1;

    // Count field is 8 bits wide, so a completely full 256-deep FIFO reports 0
    // there; software must use the full bit in that configuration.
    function automatic logic [31:0] pack_status(input logic empty,
                                                input logic full,
                                                input logic overflow,
                                                input logic [ST_COUNT_W-1:0] count);
        logic [31:0] word;
        word = '0;
        word[ST_EMPTY]    = empty;
        word[ST_FULL]     = full;
        word[ST_OVERFLOW] = overflow;
        word[ST_COUNT_LSB +: ST_COUNT_W] = count;
        return word;
    endfunction

endpackage

// File: rtl/nios_gpu_fifo_ram.sv
// FIFO storage: DEPTH x DATA_W array with one synchronous write port and an
// asynchronous read port so the head word is visible in the same cycle.
module nios_gpu_fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nios_gpu_instr_fifo.sv
// Avalon-MM instruction FIFO between the Nios CPU and the GPU command port.
// Optional interrupt logic is enabled by defining NIOS_GPU_INSTR_FIFO_IRQ_EN.
module nios_gpu_instr_fifo
    import nios_gpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] gpu_instr,
    output logic              gpu_valid,
    input  logic              gpu_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_d;
    logic [CNT_W-1:0]  count, count_d;
    logic              overflow, overflow_d;
    logic              bus_write, push_req, ctrl_write, flush, clr_ovf;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] head;
    logic [31:0]       irq_rd;
    logic              unused_writedata;

    assign bus_write  = chipselect & ~write_n;
    assign push_req   = bus_write && (address == REG_DATA);
    assign ctrl_write = bus_write && (address == REG_STATUS);
    assign flush      = ctrl_write & writedata[CTRL_FLUSH];
    assign clr_ovf    = ctrl_write & writedata[CTRL_CLR_OVF];
    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign push       = push_req & ~full & ~flush;
    assign pop        = ~empty & gpu_ready & ~flush;

    assign unused_writedata = ^writedata;

    // Flush wins over any same-cycle push or pop; a full FIFO still rejects a
    // push even when the GPU frees a slot in that very cycle.
    always_comb begin
        wr_ptr_d   = wr_ptr;
        rd_ptr_d   = rd_ptr;
        count_d    = count;
        overflow_d = overflow;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr + 1'b1;
            if (push && !pop) begin
                count_d = count + 1'b1;
            end else if (pop && !push) begin
                count_d = count - 1'b1;
            end
        end
        if (push_req && full && !flush) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_d;
            rd_ptr   <= rd_ptr_d;
            count    <= count_d;
            overflow <= overflow_d;
        end
    end

    nios_gpu_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (writedata[DATA_W-1:0]),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign gpu_instr = head;
    assign gpu_valid = ~empty;

`ifdef NIOS_GPU_INSTR_FIFO_IRQ_EN
    logic [1:0] irq_enable, irq_enable_d;
    logic       irq_d;

    // irq is computed from post-edge state so it tracks the status it reports.
    always_comb begin
        irq_enable_d = irq_enable;
        if (bus_write && (address == REG_IRQ_EN)) begin
            irq_enable_d = writedata[1:0];
        end
        irq_d = (irq_enable_d[IRQ_LOW_WATER] & (count_d == '0)) |
                (irq_enable_d[IRQ_OVERFLOW]  & overflow_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_enable <= '0;
            irq        <= 1'b0;
        end else begin
            irq_enable <= irq_enable_d;
            irq        <= irq_d;
        end
    end

    assign irq_rd = {30'b0, irq_enable};
`else
    assign irq    = 1'b0;
    assign irq_rd = '0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA:   readdata = empty ? '0 : 32'(head);
            REG_STATUS: readdata = pack_status(empty, full, overflow, ST_COUNT_W'(count));
            REG_IRQ_EN: readdata = irq_rd;
            default:    readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_gpu_instr_fifo.sv
// Scoreboard bench for nios_gpu_instr_fifo: queue-based reference model plus an
// independent monitor that checks every word the GPU side presents.
module tb_nios_gpu_instr_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] gpu_instr;
    logic        gpu_valid;
    logic        gpu_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    logic [31:0] sb_q[$];
    bit          model_ovf;
    logic [1:0]  model_en;
    bit          started = 0;

    logic [31:0] last_rd;
    logic        last_valid;
    logic        last_irq;

    always #5 clk = ~clk;

    nios_gpu_instr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .gpu_instr  (gpu_instr),
        .gpu_valid  (gpu_valid),
        .gpu_ready  (gpu_ready),
        .irq        (irq)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0] = (mq.size() == 0);
        s[1] = (mq.size() == DEPTH);
        s[2] = model_ovf;
        s[23:16] = 8'(mq.size());
        return s;
    endfunction

    function automatic logic exp_irq();
`ifdef NIOS_GPU_INSTR_FIFO_IRQ_EN
        return (model_en[0] && mq.size() == 0) || (model_en[1] && model_ovf);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_read(input logic [1:0] addr);
        case (addr)
            2'd0: return (mq.size() == 0) ? 32'h0 : mq[0];
            2'd1: return exp_status();
`ifdef NIOS_GPU_INSTR_FIFO_IRQ_EN
            2'd2: return {30'b0, model_en};
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, check pre-edge outputs against the model, then
    // advance the model by what the coming clock edge must do.
    task automatic apply_stimulus(input logic cs, input logic wn, input logic [1:0] addr,
                                  input logic [31:0] wd, input logic rdy, input logic rst);
        bit was_full;
        @(posedge clk);
        #1;
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        gpu_ready  = rdy;
        reset      = rst;
        @(negedge clk);
        last_rd    = readdata;
        last_valid = gpu_valid;
        last_irq   = irq;
        check_output("gpu_valid", {31'b0, gpu_valid}, {31'b0, mq.size() != 0});
        check_output("readdata", readdata, exp_read(addr));
        check_output("irq", {31'b0, irq}, {31'b0, exp_irq()});
        #1;
        if (rst) begin
            mq.delete();
            sb_q.delete();
            model_ovf = 0;
            model_en  = '0;
        end else if (cs && !wn && addr == 2'd1 && wd[0]) begin
            mq.delete();
            sb_q.delete();
            if (wd[1]) model_ovf = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (cs && !wn) begin
                case (addr)
                    2'd0: begin
                        if (was_full) begin
                            model_ovf = 1;
                        end else begin
                            mq.push_back(wd);
                            sb_q.push_back(wd);
                        end
                    end
                    2'd1: if (wd[1]) model_ovf = 0;
`ifdef NIOS_GPU_INSTR_FIFO_IRQ_EN
                    2'd2: model_en = wd[1:0];
`endif
                    default: ;
                endcase
            end
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data, input logic rdy);
        apply_stimulus(1'b1, 1'b0, addr, data, rdy, 1'b0);
    endtask

    task automatic rd(input logic [1:0] addr, input logic rdy);
        apply_stimulus(1'b1, 1'b1, addr, 32'h0, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        apply_stimulus(1'b0, 1'b1, 2'd0, 32'h0, rdy, 1'b0);
    endtask

    // Monitor: every presented head word must match the scoreboard front;
    // it is retired only when the handshake really consumes it.
    initial begin
        forever begin
            @(negedge clk);
            if (started && gpu_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL head_unexpected: got 0x%08h expected no entry", gpu_instr);
                end else begin
                    check_output("gpu_instr", gpu_instr, sb_q[0]);
                    if (gpu_ready && !reset &&
                        !(chipselect && !write_n && address == 2'd1 && writedata[0]))
                        void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        gpu_ready  = 1'b0;
        model_ovf  = 0;
        model_en   = '0;
        repeat (2) @(posedge clk);
        started = 1;

        // Single word round trip after reset
        rd(2'd1, 1'b0);
        check_output("reset_status", last_rd, 32'h0000_0001);
        wr(2'd0, 32'h0000_0ABC, 1'b1);
        idle(1'b1);
        check_output("abc_valid", {31'b0, last_valid}, 32'h1);
        idle(1'b1);
        check_output("abc_gone", {31'b0, last_valid}, 32'h0);
        rd(2'd1, 1'b0);
        check_output("abc_status", last_rd, 32'h0000_0001);

        // Overflow on the 17th write
        for (int i = 0; i < 17; i++) wr(2'd0, 32'h100 + i, 1'b0);
        rd(2'd1, 1'b0);
        check_output("full_status", last_rd, 32'h0010_0006);
        repeat (16) idle(1'b1);
        rd(2'd1, 1'b0);
        check_output("drained_status", last_rd, 32'h0000_0005);
        wr(2'd1, 32'h2, 1'b0);
        rd(2'd1, 1'b0);
        check_output("ovf_cleared", last_rd, 32'h0000_0001);

        // Steady push+pop at depth 3 across pointer wrap
        for (int i = 0; i < 3; i++) wr(2'd0, 32'h200 + i, 1'b0);
        for (int i = 3; i < 40; i++) wr(2'd0, 32'h200 + i, 1'b1);
        rd(2'd1, 1'b0);
        check_output("stream_count3", last_rd, 32'h0003_0000);
        repeat (3) idle(1'b1);

        // Flush plus clear-overflow while the GPU is ready
        for (int i = 0; i < 5; i++) wr(2'd0, 32'h400 + i, 1'b0);
        wr(2'd1, 32'h3, 1'b1);
        rd(2'd1, 1'b0);
        check_output("flush_status", last_rd, 32'h0000_0001);
        check_output("flush_valid", {31'b0, last_valid}, 32'h0);
        wr(2'd0, 32'h0000_0555, 1'b0);
        idle(1'b1);

        // Interrupt enable register
`ifdef NIOS_GPU_INSTR_FIFO_IRQ_EN
        wr(2'd2, 32'h1, 1'b0);
        idle(1'b0);
        check_output("irq_lowwater", {31'b0, last_irq}, 32'h1);
        wr(2'd0, 32'h0000_0666, 1'b0);
        idle(1'b0);
        check_output("irq_cleared", {31'b0, last_irq}, 32'h0);
        rd(2'd2, 1'b0);
        check_output("irq_en_read", last_rd, 32'h1);
        idle(1'b1);
        wr(2'd2, 32'h0, 1'b0);
`else
        wr(2'd2, 32'h3, 1'b0);
        rd(2'd2, 1'b0);
        check_output("irq_en_absent", last_rd, 32'h0);
        check_output("irq_tied", {31'b0, last_irq}, 32'h0);
`endif

        // Reset mid-operation
        wr(2'd2, 32'h1, 1'b0);
        for (int i = 0; i < 4; i++) wr(2'd0, 32'h700 + i, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
        rd(2'd1, 1'b0);
        check_output("rst_status", last_rd, 32'h0000_0001);
        check_output("rst_valid", {31'b0, last_valid}, 32'h0);
        check_output("rst_irq", {31'b0, last_irq}, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic        rdy;
            logic [31:0] d;
            r   = $urandom_range(0, 99);
            rdy = ($urandom_range(0, 9) < 4);
            d   = $urandom;
            if (r < 1) begin
                apply_stimulus(1'b0, 1'b1, 2'd0, 32'h0, rdy, 1'b1);
            end else if (r < 50) begin
                wr(2'd0, d, rdy);
            end else if (r < 54) begin
                wr(2'd1, (d & 32'hFFFF_FFFE) | {31'b0, r == 50}, rdy);
            end else if (r < 58) begin
                wr(2'($urandom_range(2, 3)), d, rdy);
            end else if (r < 80) begin
                rd(2'($urandom_range(0, 3)), rdy);
            end else begin
                idle(rdy);
            end
        end
        repeat (DEPTH + 1) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios_gpu_instr_fifo.md
NIOS_GPU_INSTR_FIFO -- requirements
Module: nios_gpu_instr_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width (8..32).
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 2..256).
REQ-003 SHALL have port clk  input  1  sole clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  input  2  Avalon-MM register select.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-007 SHALL have port write_n  input  1  active-low Avalon-MM write strobe.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  Avalon-MM read data, combinational, zero wait states.
REQ-010 SHALL have port gpu_instr  output  DATA_W  instruction word at the FIFO head.
REQ-011 SHALL have port gpu_valid  output  1  high when gpu_instr holds a valid entry.
REQ-012 SHALL have port gpu_ready  input  1  GPU accepts the head entry.
REQ-013 SHALL have port irq  output  1  level interrupt to Nios (see Configuration).

Function
REQ-014 SHALL treat write = chipselect & ~write_n.
REQ-015 SHALL push writedata[DATA_W-1:0] on a write to address 0 when not full; upper bits are ignored.
REQ-016 SHALL reject a push when full, leave contents unchanged, and set the sticky overflow flag, even if a pop occurs in the same cycle.
REQ-017 SHALL pop on any cycle where gpu_valid & gpu_ready.
REQ-018 SHALL hold gpu_valid = (count != 0) with no bypass: a word pushed at cycle N appears on gpu_instr/gpu_valid at N+1.
REQ-019 SHALL keep count unchanged on simultaneous accepted push and pop when not full.
REQ-020 SHALL hold gpu_instr stable while gpu_valid & ~gpu_ready.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count width is clog2(DEPTH)+1.
REQ-022 SHALL return on read of address 0 the head word zero-extended (0 if empty), without popping.
REQ-023 SHALL return on read of address 1 the status word: bit0 empty, bit1 full, bit2 overflow, bits[23:16] count, others 0.
REQ-024 SHALL on a write to address 1 flush (pointers and count to 0) when writedata[0]=1 and clear overflow when writedata[1]=1.
REQ-025 SHALL give flush priority over a same-cycle push or pop; the push is dropped without setting overflow.
REQ-026 SHALL return 0 for reads of address 3 and ignore writes to it.

Reset
REQ-027 SHALL on reset clear pointers, count, overflow and irq_enable, giving gpu_valid=0, irq=0, and status reading 0x0000_0001.
REQ-028 SHALL discard all queued entries on reset asserted mid-operation; storage contents need not be cleared.

Configuration
REQ-029 SHALL, with macro NIOS_GPU_INSTR_FIFO_IRQ_EN defined, provide an irq_enable register at address 2 (bit0 low-water, bit1 overflow), readable back, and drive irq registered = (en[0] & empty) | (en[1] & overflow).
REQ-030 SHALL, without NIOS_GPU_INSTR_FIFO_IRQ_EN, tie irq to 0, return 0 for reads of address 2 and ignore writes to it.

Structure
REQ-031 SHALL place register address constants (REG_DATA=0, REG_STATUS=1, REG_IRQ_EN=2) and status/control bit positions in shared package nios_gpu_pkg.
REQ-032 SHALL instantiate storage in one sub-module nios_gpu_fifo_ram (DEPTH x DATA_W, one write port, asynchronous read port).

Verification
REQ-033 SHALL cover: reset, write 0x00000ABC to address 0, gpu_ready=1 -> gpu_valid high one cycle later with gpu_instr=0xABC, then low; status returns 0x0000_0001.
REQ-034 SHALL cover: gpu_ready=0, 17 writes with DEPTH=16 -> status = count 16, full=1, overflow=1 (0x0010_0006); 17th word absent from drained sequence.
REQ-035 SHALL cover: FIFO holding 3 entries, push and pop in the same cycle -> count stays 3, order preserved across pointer wrap after 40 total words.
REQ-036 SHALL cover: write 0x3 to address 1 together with gpu_ready=1 while holding 5 entries -> count 0, overflow 0, gpu_valid 0 next cycle, no extra pop.
REQ-037 SHALL cover: with NIOS_GPU_INSTR_FIFO_IRQ_EN, write 0x1 to address 2 while empty -> irq=1 next cycle; push one word -> irq=0; without the macro irq stays 0 and address 2 reads 0.
REQ-038 SHALL cover: reset asserted while holding 4 entries and gpu_ready=0 -> next cycle gpu_valid=0, count 0, irq 0.
